sub_arbiter: RTL and testbench
==============================

SUB_ARBITER -- requirements
Module: sub_arbiter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, which is the operand/result width in bits.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state SHALL change on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The block SHALL have port req, input, 2 bits: request from requester i (i = 0, 1); once raised it is held until ack[i].
REQ-005 The block SHALL have ports a0, b0, input, WIDTH each: requester-0 operands, computed as a0 - b0.
REQ-006 The block SHALL have ports a1, b1, input, WIDTH each: requester-1 operands, computed as a1 - b1.
REQ-007 The block SHALL have port ack, output, 2 bits: one-cycle grant pulse; operands of the granted requester are captured in that cycle.
REQ-008 The block SHALL have port rsp_valid, output, 1 bit: result available.
REQ-009 The block SHALL have port rsp_ready, input, 1 bit: consumer accepts the result.
REQ-010 The block SHALL have port rsp_id, output, 1 bit: index of the requester owning the result.
REQ-011 The block SHALL have port res, output, WIDTH: the difference.
REQ-012 The block SHALL have port borrow, output, 1 bit: 1 when minuend < subtrahend (unsigned).
REQ-013 The block SHALL have port busy, output, 1 bit: 1 in any state other than IDLE.

Function
REQ-014 The FSM SHALL have states IDLE, EXEC, DONE.
REQ-015 In IDLE with req != 0, the block SHALL grant one requester, pulse ack for that requester, capture its operands and enter EXEC, all in the same cycle.
REQ-016 Requests SHALL be sampled only in IDLE; req changes in EXEC or DONE SHALL be ignored.
REQ-017 When exactly one req bit is set, that requester SHALL be granted.
REQ-018 When both req bits are set, the requester equal to the priority pointer prio SHALL be granted.
REQ-019 After every grant, prio SHALL be set to the non-granted index (round-robin).
REQ-020 EXEC SHALL last exactly 1 cycle, during which the subtractor sub-unit registers the result, then the FSM SHALL enter DONE.
REQ-021 In DONE, rsp_valid SHALL be 1.
REQ-022 res, borrow and rsp_id SHALL be stable while rsp_valid = 1 and rsp_ready = 0.
REQ-023 In DONE with rsp_ready = 1, the handshake SHALL complete and the FSM SHALL return to IDLE the next cycle.
REQ-024 A new grant SHALL be possible on the first IDLE cycle, giving a minimum of 3 cycles per operation.
REQ-025 res SHALL equal (minuend - subtrahend) mod 2^WIDTH.
REQ-026 borrow SHALL equal the unsigned comparison minuend < subtrahend.
REQ-027 For equal operands, res SHALL be 0 and borrow SHALL be 0.
REQ-028 rsp_ready asserted outside DONE SHALL have no effect.
REQ-029 ack SHALL never have both bits set, and SHALL be 0 outside IDLE.

Reset
REQ-030 While rst = 0, the block SHALL hold state = IDLE, prio = 0, ack = 0, rsp_valid = 0, rsp_id = 0, res = 0, borrow = 0, busy = 0.
REQ-031 Reset asserted mid-operation (in EXEC or DONE) SHALL abort that operation; no response SHALL be produced for it and prio SHALL return to 0.
REQ-032 On the first rising edge after rst deasserts, pending requests SHALL be arbitrated normally, with requester 0 winning a tie.

Structure
REQ-033 A shared package sub_pkg SHALL hold the state enum (IDLE, EXEC, DONE) and the WIDTH default constant.
REQ-034 One sub-module, sub_unit, SHALL be instantiated: a registered WIDTH-bit subtractor with inputs a, b, en, clk, rst and outputs sub, borrow, loading only when en = 1.
REQ-035 The arbitration/FSM logic SHALL reside in sub_arbiter itself.

Verification
REQ-036 Single request: req = 01, a0 = 0x000F, b0 = 0x0005 -> ack = 01 in cycle 0; rsp_valid in cycle 2 with res = 0x000A, borrow = 0, rsp_id = 0.
REQ-037 Borrow wrap: req = 10, a1 = 0x0005, b1 = 0x000C -> res = 0xFFF9, borrow = 1, rsp_id = 1.
REQ-038 Tie after reset: req = 11 held, rsp_ready = 1, operands 0x0008/0x0008 and 0x000D/0x0002 -> grant order 0, 1, 0, 1; results 0x0000 (borrow 0) and 0x000B alternate.
REQ-039 Back-pressure: rsp_ready = 0 for 5 cycles in DONE -> rsp_valid, res and rsp_id held constant, no ack issued; response completes one cycle after rsp_ready = 1.
REQ-040 Reset mid-op: rst = 0 during EXEC -> all outputs zero, no rsp_valid afterward; with req = 11 after release, requester 0 is granted first.
REQ-041 Boundary values: 0x0000 - 0xFFFF -> res = 0x0001, borrow = 1; 0xFFFF - 0x0000 -> res = 0xFFFF, borrow = 0.

Source files
------------

// File: rtl/sub_pkg.sv
// Shared definitions for the two-requester subtract arbiter.
package sub_pkg;

    localparam int WIDTH_DEF = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/sub_unit.sv
// Registered unsigned subtractor; result and borrow load only when en is high.
module sub_unit
    import sub_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] sub,
    output logic             borrow
);

    // The extra top bit of the widened difference is exactly the unsigned a < b flag.
    logic [WIDTH:0] diff;

    assign diff = {1'b0, a} - {1'b0, b};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sub    <= '0;
            borrow <= 1'b0;
        end else if (en) begin
            sub    <= diff[WIDTH-1:0];
            borrow <= diff[WIDTH];
        end
    end

endmodule

// File: rtl/sub_arbiter.sv
// Round-robin arbiter for two requesters sharing one registered subtractor.
module sub_arbiter
    import sub_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       req,
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] b0,
    input  logic [WIDTH-1:0] a1,
    input  logic [WIDTH-1:0] b1,
    output logic [1:0]       ack,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] res,
    output logic             borrow,
    output logic             busy
);

    state_t           state;
    logic             prio;
    logic             gnt_id;
    logic [1:0]       grant;
    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;

    always_comb begin
        grant  = 2'b00;
        gnt_id = 1'b0;
        case (req)
            2'b01: begin
                grant  = 2'b01;
                gnt_id = 1'b0;
            end
            2'b10: begin
                grant  = 2'b10;
                gnt_id = 1'b1;
            end
            2'b11: begin
                grant  = prio ? 2'b10 : 2'b01;
                gnt_id = prio;
            end
            default: begin
                grant  = 2'b00;
                gnt_id = 1'b0;
            end
        endcase
    end

    // Gated by rst so that pending requests cannot pulse ack while held in reset.
    assign ack       = (rst && state == IDLE) ? grant : 2'b00;
    assign rsp_valid = (state == DONE);
    assign busy      = (state != IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            prio   <= 1'b0;
            rsp_id <= 1'b0;
            opa    <= '0;
            opb    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req != 2'b00) begin
                        state  <= EXEC;
                        prio   <= ~gnt_id;
                        rsp_id <= gnt_id;
                        opa    <= gnt_id ? a1 : a0;
                        opb    <= gnt_id ? b1 : b0;
                    end
                end
                EXEC: state <= DONE;
                DONE: begin
                    if (rsp_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Result registers only load in EXEC, so they stay frozen through DONE back-pressure.
    sub_unit #(
        .WIDTH(WIDTH)
    ) u_sub (
        .clk   (clk),
        .rst   (rst),
        .en    (state == EXEC),
        .a     (opa),
        .b     (opb),
        .sub   (res),
        .borrow(borrow)
    );

endmodule

// File: tb/tb_sub_arbiter.sv
// Table-driven and scoreboard bench for sub_arbiter, plus back-pressure and mid-op reset sequences.
module tb_sub_arbiter;
    import sub_pkg::*;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic [1:0]   req;
    logic [W-1:0] a0, b0, a1, b1;
    logic [1:0]   ack;
    logic         rsp_valid;
    logic         rsp_ready;
    logic         rsp_id;
    logic [W-1:0] res;
    logic         borrow;
    logic         busy;

    always #5 clk = ~clk;

    sub_arbiter #(
        .WIDTH(W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .a0       (a0),
        .b0       (b0),
        .a1       (a1),
        .b1       (b1),
        .ack      (ack),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_id   (rsp_id),
        .res      (res),
        .borrow   (borrow),
        .busy     (busy)
    );

    typedef struct {
        logic [1:0]   req;
        logic [W-1:0] a0;
        logic [W-1:0] b0;
        logic [W-1:0] a1;
        logic [W-1:0] b1;
        logic [1:0]   ack;
        logic         id;
        logic [W-1:0] res;
        logic         brw;
    } vec_t;

    typedef struct {
        logic         id;
        logic [W-1:0] res;
        logic         brw;
    } exp_t;

    exp_t sbq[$];
    vec_t vecs[10];
    int   checks   = 0;
    int   failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic pop_cmp(input string name);
        exp_t e;
        if (sbq.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL %s unexpected response actual_res=0x%0h required=none", name, res);
        end else begin
            e = sbq.pop_front();
            check({name, " rsp_id"}, 32'(rsp_id), 32'(e.id));
            check({name, " res"},    32'(res),    32'(e.res));
            check({name, " borrow"}, 32'(borrow), 32'(e.brw));
        end
    endtask

    // Waits for rsp_valid within a cycle budget; lat counts negedges waited.
    task automatic expect_rsp(input string name, input int budget, output int lat);
        lat = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            #1;
            if (rsp_valid) begin
                lat = i + 1;
                break;
            end
        end
        if (lat < 0) begin
            checks++;
            failures++;
            $display("FAIL %s timeout actual=no_rsp_valid required=rsp_valid", name);
        end else begin
            pop_cmp(name);
        end
    endtask

    task automatic run_vec(input vec_t v, input string name);
        int lat;
        @(negedge clk);
        req       = v.req;
        a0        = v.a0;
        b0        = v.b0;
        a1        = v.a1;
        b1        = v.b1;
        rsp_ready = 1'b1;
        #1;
        check({name, " ack"}, 32'(ack), 32'(v.ack));
        sbq.push_back('{v.id, v.res, v.brw});
        @(negedge clk);
        #1;
        check({name, " exec_busy"}, 32'(busy), 32'd1);
        check({name, " exec_ack"},  32'(ack),  32'd0);
        expect_rsp(name, 6, lat);
        if (lat >= 0) check({name, " latency"}, 32'(lat), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        //              req    a0       b0       a1       b1       ack    id    res      brw
        vecs[0] = '{2'b01, 16'h000F, 16'h0005, 16'h0000, 16'h0000, 2'b01, 1'b0, 16'h000A, 1'b0};
        vecs[1] = '{2'b10, 16'h0000, 16'h0000, 16'h0005, 16'h000C, 2'b10, 1'b1, 16'hFFF9, 1'b1};
        vecs[2] = '{2'b11, 16'h0008, 16'h0008, 16'h000D, 16'h0002, 2'b01, 1'b0, 16'h0000, 1'b0};
        vecs[3] = '{2'b11, 16'h0008, 16'h0008, 16'h000D, 16'h0002, 2'b10, 1'b1, 16'h000B, 1'b0};
        vecs[4] = '{2'b11, 16'h0008, 16'h0008, 16'h000D, 16'h0002, 2'b01, 1'b0, 16'h0000, 1'b0};
        vecs[5] = '{2'b11, 16'h0008, 16'h0008, 16'h000D, 16'h0002, 2'b10, 1'b1, 16'h000B, 1'b0};
        vecs[6] = '{2'b01, 16'h0000, 16'hFFFF, 16'h1111, 16'h2222, 2'b01, 1'b0, 16'h0001, 1'b1};
        vecs[7] = '{2'b10, 16'h3333, 16'h4444, 16'hFFFF, 16'h0000, 2'b10, 1'b1, 16'hFFFF, 1'b0};
        vecs[8] = '{2'b01, 16'h1234, 16'h0234, 16'h0000, 16'h0000, 2'b01, 1'b0, 16'h1000, 1'b0};
        vecs[9] = '{2'b11, 16'h0001, 16'h0002, 16'h0007, 16'h0003, 2'b10, 1'b1, 16'h0004, 1'b0};

        // Reset held with requests pending.
        rst       = 1'b0;
        req       = 2'b11;
        a0        = 16'h00AA;
        b0        = 16'h0011;
        a1        = 16'h00BB;
        b1        = 16'h0022;
        rsp_ready = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        check("reset ack",       32'(ack),       32'd0);
        check("reset rsp_valid", 32'(rsp_valid), 32'd0);
        check("reset busy",      32'(busy),      32'd0);
        check("reset res",       32'(res),       32'd0);
        check("reset borrow",    32'(borrow),    32'd0);
        check("reset rsp_id",    32'(rsp_id),    32'd0);
        req = 2'b00;
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 10; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
        end

        // Back-pressure: result frozen in DONE while req=11 is ignored.
        @(negedge clk);
        req       = 2'b01;
        a0        = 16'h0020;
        b0        = 16'h0003;
        rsp_ready = 1'b0;
        #1;
        check("bp ack", 32'(ack), 32'd1);
        sbq.push_back('{1'b0, 16'h001D, 1'b0});
        @(negedge clk);
        req = 2'b11;
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            #1;
            check($sformatf("bp hold%0d rsp_valid", i), 32'(rsp_valid), 32'd1);
            check($sformatf("bp hold%0d res", i),       32'(res),       32'h001D);
            check($sformatf("bp hold%0d rsp_id", i),    32'(rsp_id),    32'd0);
            check($sformatf("bp hold%0d ack", i),       32'(ack),       32'd0);
            @(negedge clk);
        end
        req       = 2'b00;
        rsp_ready = 1'b1;
        #1;
        pop_cmp("bp rsp");
        @(negedge clk);
        #1;
        check("bp done rsp_valid", 32'(rsp_valid), 32'd0);
        check("bp done busy",      32'(busy),      32'd0);

        // Reset during EXEC aborts the operation and clears prio.
        @(negedge clk);
        req = 2'b01;
        a0  = 16'h0009;
        b0  = 16'h0004;
        #1;
        check("mid ack", 32'(ack), 32'd1);
        @(negedge clk);
        req = 2'b00;
        #1;
        check("mid exec busy", 32'(busy), 32'd1);
        rst = 1'b0;
        #1;
        check("mid rst ack",       32'(ack),       32'd0);
        check("mid rst rsp_valid", 32'(rsp_valid), 32'd0);
        check("mid rst busy",      32'(busy),      32'd0);
        check("mid rst res",       32'(res),       32'd0);
        check("mid rst borrow",    32'(borrow),    32'd0);
        check("mid rst rsp_id",    32'(rsp_id),    32'd0);
        @(negedge clk);
        #1;
        check("mid rst hold rsp_valid", 32'(rsp_valid), 32'd0);
        req = 2'b11;
        a0  = 16'h0006;
        b0  = 16'h0006;
        a1  = 16'h0003;
        b1  = 16'h0001;
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("post rst ack", 32'(ack), 32'd1);
        sbq.push_back('{1'b0, 16'h0000, 1'b0});
        begin
            int lat;
            expect_rsp("post rst op0", 8, lat);
            if (lat >= 0) check("post rst op0 latency", 32'(lat), 32'd2);
        end
        run_vec('{2'b11, 16'h0006, 16'h0006, 16'h0003, 16'h0001, 2'b10, 1'b1, 16'h0002, 1'b0}, "post rst op1");

        check("scoreboard empty", 32'(sbq.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
